// File: rtl/pipe_commit_monitor.sv
// Tracks one token through an NSTG-stage stallable pipeline. Reports the commit,
// the on-time end with its latency, timeout, token loss and duplicate commits.
module pipe_commit_monitor #(
    parameter int NSTG   = 4,
    parameter int CNT_W  = 8,
    parameter int WINDOW = 50,
    parameter int SAT    = 132
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic [NSTG-1:0]  stall,
    output logic             start,
    output logic             started,
    output logic [NSTG-1:0]  tok,
    output logic             commit,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             end_pulse,
    output logic             ended,
    output logic             end2,
    output logic             timeout,
    output logic [CNT_W-1:0] latency,
    output logic             tok_lost
);

    localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] SAT_C = CNT_W'(SAT);

    logic             start_reg, start_next;
    logic             started_reg, started_next;
    logic [NSTG-1:1]  tok_reg, tok_next;
    logic [NSTG-1:1]  lost_vec;
    logic             commit_reg, commit_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ended_reg, ended_next;
    logic             end2_reg, end2_next;
    logic             timeout_reg, timeout_next;
    logic [CNT_W-1:0] latency_reg, latency_next;
    logic             tok_lost_reg, tok_lost_next;
    logic             end_comb;

    // Stage 0 occupancy is the launch pulse itself.
    assign tok = {tok_reg, start_reg};

    generate
        for (genvar gi = 1; gi < NSTG; gi++) begin : g_stage
            assign tok_next[gi] = stall[gi] ? tok[gi] : (tok[gi-1] & ~stall[gi-1]);
            assign lost_vec[gi] = tok[gi-1] & ~stall[gi-1] & stall[gi];
        end
    endgenerate

    assign end_comb = commit_reg & started_reg & ~ended_reg & (cnt_reg <= WIN_C);

    always_comb begin
        start_next    = issue & ~start_reg & ~started_reg;
        started_next  = started_reg | start_reg;
        commit_next   = tok[NSTG-1] & ~stall[NSTG-1];
        cnt_next      = cnt_reg;
        if ((start_reg | started_reg) && (cnt_reg < SAT_C))
            cnt_next = cnt_reg + 1'b1;
        ended_next    = ended_reg | end_comb;
        end2_next     = end2_reg | (ended_reg & commit_reg & started_reg);
        timeout_next  = timeout_reg | (started_reg & ~ended_reg & (cnt_reg > WIN_C));
        latency_next  = end_comb ? cnt_reg : latency_reg;
        tok_lost_next = tok_lost_reg | (|lost_vec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_reg    <= 1'b0;
            started_reg  <= 1'b0;
            tok_reg      <= '0;
            commit_reg   <= 1'b0;
            cnt_reg      <= '0;
            ended_reg    <= 1'b0;
            end2_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            latency_reg  <= '0;
            tok_lost_reg <= 1'b0;
        end else begin
            start_reg    <= start_next;
            started_reg  <= started_next;
            tok_reg      <= tok_next;
            commit_reg   <= commit_next;
            cnt_reg      <= cnt_next;
            ended_reg    <= ended_next;
            end2_reg     <= end2_next;
            timeout_reg  <= timeout_next;
            latency_reg  <= latency_next;
            tok_lost_reg <= tok_lost_next;
        end
    end

    assign start     = start_reg;
    assign started   = started_reg;
    assign commit    = commit_reg;
    assign cycle_cnt = cnt_reg;
    assign end_pulse = end_comb;
    assign ended     = ended_reg;
    assign end2      = end2_reg;
    assign timeout   = timeout_reg;
    assign latency   = latency_reg;
    assign tok_lost  = tok_lost_reg;

endmodule
